// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory between instruction fetch and
//                the load/store unit; LS priority with a fetch starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  fetch_stall,
    input  logic                  flush,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_be,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic [c_cnt_w-1:0] w_starve_nxt;
    logic               r_drop;
    logic               w_drop_nxt;
    logic               w_can_issue;
    logic               w_eligible_if;
    logic               w_starved;
    logic               w_busy_if;
    logic               w_busy_ls;

    assign w_busy_if     = (r_state == ST_BUSY_IF);
    assign w_busy_ls     = (r_state == ST_BUSY_LS);
    assign w_starved     = (r_starve_cnt == c_starve_max);
    assign w_eligible_if = if_req & ~flush;
    // A new transaction may issue when idle or on the completion cycle of the current one
    assign w_can_issue   = reset_n & ((r_state == ST_IDLE) | mem_rvalid);

    assign if_gnt      = w_can_issue & w_eligible_if & (~ls_req | w_starved);
    assign ls_gnt      = w_can_issue & ls_req & ~(w_eligible_if & w_starved);
    assign fetch_stall = if_req & ~if_gnt;
    assign mem_req     = if_gnt | ls_gnt;

    assign if_rvalid = mem_rvalid & w_busy_if & ~r_drop;
    assign ls_rvalid = mem_rvalid & w_busy_ls;
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (ls_gnt) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_drop_nxt   = r_drop;

        if (if_gnt) begin
            w_state_nxt = ST_BUSY_IF;
        end else if (ls_gnt) begin
            w_state_nxt = ST_BUSY_LS;
        end else if (mem_rvalid || !(w_busy_if || w_busy_ls)) begin
            w_state_nxt = ST_IDLE;
        end

        if (!if_req || if_gnt) begin
            w_starve_nxt = '0;
        end else if (ls_gnt && !w_starved) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end

        // A returning fetch response always retires the drop, even if flush coincides
        if (mem_rvalid && w_busy_if) begin
            w_drop_nxt = 1'b0;
        end else if (flush && (w_busy_if || if_gnt)) begin
            w_drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_drop       <= w_drop_nxt;
        end
    end

endmodule
`default_nettype wire
